// File: rtl/lcd_spi_pkg.sv
// Shared types and widths for the SPI LCD link scheduler.
package lcd_spi_pkg;

    localparam int unsigned LCD_BYTE_W = 8;
    localparam int unsigned LCD_RS_BIT = 8;
    localparam int unsigned LCD_CMD_W  = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CS_HOLD,
        GAP
    } state_e;

endpackage

// File: rtl/lcd_spi_byte_tx.sv
// SCK divider and MSB-first byte shifter: mode 0, SCK idle low, data changes only
// at the start of each low phase; done_c_o marks the edge that ends bit 0's high phase.
module lcd_spi_byte_tx
    import lcd_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [LCD_BYTE_W-1:0] byte_i,
    input  logic                  release_i,
    output logic                  sck_o,
    output logic                  sdo_o,
    output logic                  done_c_o
);

    localparam int unsigned HW = $clog2(CLK_DIV + 1);

    logic                  active_q;
    logic                  sck_q;
    logic                  sdo_q;
    logic [LCD_BYTE_W-2:0] sh_q;
    logic [HW-1:0]         half_q;
    logic [2:0]            bit_q;
    logic                  phase_end_c;

    assign phase_end_c = active_q && (half_q == '0);
    assign done_c_o    = phase_end_c && sck_q && (bit_q == 3'd0);
    assign sck_o       = sck_q;
    assign sdo_o       = sdo_q;

    // MSB goes out on the load edge; remaining bits wait in sh_q
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b1;
            sh_q     <= '0;
            half_q   <= '0;
            bit_q    <= 3'd0;
        end else if (start_i) begin
            active_q <= 1'b1;
            sck_q    <= 1'b0;
            sdo_q    <= byte_i[LCD_BYTE_W-1];
            sh_q     <= byte_i[LCD_BYTE_W-2:0];
            half_q   <= HW'(CLK_DIV - 1);
            bit_q    <= 3'd7;
        end else if (release_i) begin
            sdo_q <= 1'b1;
        end else if (phase_end_c) begin
            half_q <= HW'(CLK_DIV - 1);
            if (!sck_q) begin
                sck_q <= 1'b1;
            end else begin
                sck_q <= 1'b0;
                if (bit_q == 3'd0) begin
                    active_q <= 1'b0;
                end else begin
                    bit_q <= bit_q - 3'd1;
                    sdo_q <= sh_q[LCD_BYTE_W-2];
                    sh_q  <= {sh_q[LCD_BYTE_W-3:0], 1'b0};
                end
            end
        end else if (active_q) begin
            half_q <= half_q - HW'(1);
        end
    end

endmodule

// File: rtl/lcd_spi_sched.sv
// Burst arbiter sharing one SPI LCD link between two byte-stream requesters.
// LCD_SPI_RR_EN selects round-robin arbitration; otherwise req0 has fixed priority.
module lcd_spi_sched
    import lcd_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid_i,
    input  logic [LCD_CMD_W-1:0] req0_data_i,
    input  logic                 req0_last_i,
    output logic                 req0_ready_o,
    input  logic                 req1_valid_i,
    input  logic [LCD_CMD_W-1:0] req1_data_i,
    input  logic                 req1_last_i,
    output logic                 req1_ready_o,
    output logic [1:0]           grant_o,
    output logic                 busy_o,
    output logic                 lcd_cs_o,
    output logic                 lcd_clk_o,
    output logic                 lcd_rs_o,
    output logic                 lcd_data_o
);

    localparam int unsigned HW = $clog2(CLK_DIV + 1);
    localparam int unsigned GW = $clog2(CS_GAP + 1);

    state_e               state_q;
    logic [1:0]           grant_q;
    logic                 busy_q;
    logic                 cs_q;
    logic                 rs_q;
    logic                 last_q;
    logic [HW-1:0]        hold_q;
    logic [GW-1:0]        gap_q;

    logic [1:0]           win_c;
    logic                 sel_valid_c;
    logic                 sel_last_c;
    logic [LCD_CMD_W-1:0] sel_data_c;
    logic                 xfer_c;
    logic                 release_c;
    logic                 done_c;

`ifdef LCD_SPI_RR_EN
    logic rr_last_q;

    // rr_last_q holds the previous winner; a tie goes to the other requester
    always_comb begin
        win_c = 2'b00;
        if (req0_valid_i && req1_valid_i) begin
            win_c = rr_last_q ? 2'b01 : 2'b10;
        end else if (req0_valid_i) begin
            win_c = 2'b01;
        end else if (req1_valid_i) begin
            win_c = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= 1'b1;
        end else if ((state_q == IDLE) && (win_c != 2'b00)) begin
            rr_last_q <= win_c[1];
        end
    end
`else
    always_comb begin
        win_c = 2'b00;
        if (req0_valid_i) begin
            win_c = 2'b01;
        end else if (req1_valid_i) begin
            win_c = 2'b10;
        end
    end
`endif

    // Route the granted requester's stream to the shifter
    always_comb begin
        sel_valid_c = 1'b0;
        sel_last_c  = 1'b0;
        sel_data_c  = '0;
        if (grant_q[0]) begin
            sel_valid_c = req0_valid_i;
            sel_last_c  = req0_last_i;
            sel_data_c  = req0_data_i;
        end else if (grant_q[1]) begin
            sel_valid_c = req1_valid_i;
            sel_last_c  = req1_last_i;
            sel_data_c  = req1_data_i;
        end
    end

    assign xfer_c       = (state_q == LOAD) && sel_valid_c;
    assign release_c    = (state_q == CS_HOLD) && (hold_q == '0);
    assign req0_ready_o = (state_q == LOAD) && grant_q[0] && req0_valid_i;
    assign req1_ready_o = (state_q == LOAD) && grant_q[1] && req1_valid_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            cs_q    <= 1'b1;
            rs_q    <= 1'b1;
            last_q  <= 1'b0;
            hold_q  <= '0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_c != 2'b00) begin
                        grant_q <= win_c;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (xfer_c) begin
                        rs_q    <= sel_data_c[LCD_RS_BIT];
                        last_q  <= sel_last_c;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (done_c) begin
                        if (last_q) begin
                            hold_q  <= HW'(CLK_DIV - 1);
                            state_q <= CS_HOLD;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                CS_HOLD: begin
                    if (hold_q == '0) begin
                        cs_q    <= 1'b1;
                        rs_q    <= 1'b1;
                        gap_q   <= GW'(CS_GAP - 1);
                        state_q <= GAP;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                GAP: begin
                    if (gap_q == '0) begin
                        grant_q <= 2'b00;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    lcd_spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_byte_tx (
        .clk       (clk),
        .reset     (reset),
        .start_i   (xfer_c),
        .byte_i    (sel_data_c[LCD_BYTE_W-1:0]),
        .release_i (release_c),
        .sck_o     (lcd_clk_o),
        .sdo_o     (lcd_data_o),
        .done_c_o  (done_c)
    );

    assign grant_o  = grant_q;
    assign busy_o   = busy_q;
    assign lcd_cs_o = cs_q;
    assign lcd_rs_o = rs_q;

endmodule

// File: tb/tb_lcd_spi_sched.sv
// Scoreboard bench: drivers queue expected {last,rs,byte} per requester; a pin monitor
// rebuilds bytes from SCK rises and checks them, plus grant, ready and timing rules.
module tb_lcd_spi_sched;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned CS_GAP  = 3;
    localparam int unsigned BYTE_T  = 16 * CLK_DIV;
`ifdef LCD_SPI_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic [1:0]      req_valid;
    logic [1:0][8:0] req_data;
    logic [1:0]      req_last;
    logic [1:0]      req_ready;
    logic [1:0]      grant;
    logic            busy, lcd_cs, lcd_clk, lcd_rs, lcd_data;

    lcd_spi_sched #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid_i (req_valid[0]),
        .req0_data_i  (req_data[0]),
        .req0_last_i  (req_last[0]),
        .req0_ready_o (req_ready[0]),
        .req1_valid_i (req_valid[1]),
        .req1_data_i  (req_data[1]),
        .req1_last_i  (req_last[1]),
        .req1_ready_o (req_ready[1]),
        .grant_o      (grant),
        .busy_o       (busy),
        .lcd_cs_o     (lcd_cs),
        .lcd_clk_o    (lcd_clk),
        .lcd_rs_o     (lcd_rs),
        .lcd_data_o   (lcd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Monitor state
    int         bits, low_len, hi_len, hi_run, last_win, mon_low_len, mon_gap_len;
    int         rdy_cnt[2];
    logic [7:0] sh;
    logic       rs_at, bit_at_rise, data_moved, last_seen, have_gap;
    logic       prev_cs, prev_sck;
    logic [1:0] prev_v, burst_grant, eg;
    logic [9:0] e;
    int         mw;

    always @(negedge clk) begin
        if (reset) begin
            bits = 0; hi_run = 0; data_moved = 0; last_seen = 0;
            have_gap = 0; last_win = 1; burst_grant = 2'b00;
        end else begin
            // Burst start: winner predicted from who was requesting at the decision edge
            if (!lcd_cs && prev_cs) begin
                if (prev_v == 2'b11) mw = RR ? ((last_win == 1) ? 0 : 1) : 0;
                else mw = prev_v[0] ? 0 : 1;
                eg = 2'b01 << mw;
                chk(grant == eg, "grant_at_start", 32'(grant), 32'(eg));
                last_win = mw; burst_grant = eg; low_len = 0; last_seen = 0;
                if (have_gap) begin
                    mon_gap_len = hi_len;
                    chk(hi_len >= int'(CS_GAP + 1), "cs_gap_len", 32'(hi_len), 32'(CS_GAP + 1));
                end
            end
            if (!lcd_cs) begin
                low_len++;
                chk(grant == burst_grant && busy, "grant_busy_hold", 32'({grant, busy}), 32'({burst_grant, 1'b1}));
            end else if (!prev_cs) begin
                mon_low_len = low_len;
                chk(bits == 0 && last_seen, "burst_end", 32'({bits[3:0], last_seen}), 32'h1);
                hi_len = 1; have_gap = 1;
            end else begin
                hi_len++;
            end
            for (int r = 0; r < 2; r++) begin
                if (req_ready[r]) begin
                    rdy_cnt[r]++;
                    chk(grant == (2'b01 << r) && req_valid[r], "ready_only_granted",
                        32'({grant, req_valid[r]}), 32'({2'b01 << r, 1'b1}));
                end
            end
            if (lcd_clk && !prev_sck) begin
                sh = {sh[6:0], lcd_data}; rs_at = lcd_rs; bits++;
                hi_run = 1; bit_at_rise = lcd_data; data_moved = 0;
                if (bits == 8) begin
                    bits = 0;
                    if ((burst_grant[1] ? q1.size() : q0.size()) == 0) begin
                        chk(1'b0, "unexpected_byte", 32'({rs_at, sh}), 32'h0);
                    end else begin
                        e = burst_grant[1] ? q1.pop_front() : q0.pop_front();
                        chk({rs_at, sh} == e[8:0], "spi_byte", 32'({rs_at, sh}), 32'(e[8:0]));
                        last_seen = e[9];
                    end
                end
            end else if (lcd_clk) begin
                hi_run++;
                if (lcd_data != bit_at_rise) data_moved = 1;
            end else if (prev_sck) begin
                chk(hi_run == int'(CLK_DIV) && !data_moved, "sck_high_phase", 32'(hi_run), 32'(CLK_DIV));
            end
        end
        prev_cs = lcd_cs; prev_sck = lcd_clk; prev_v = req_valid;
    end

    task automatic drive_burst(input int r, input int n, input int stall, input int dly,
                               input logic [8:0] w0, input logic [8:0] w1, input bit rnd);
        logic [8:0] w;
        bit ok;
        @(posedge clk);
        repeat (dly) @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            w = rnd ? 9'($urandom) : ((i == 0) ? w0 : w1);
            if (r == 0) q0.push_back({1'(i == n - 1), w});
            else        q1.push_back({1'(i == n - 1), w});
            req_valid[r] = 1'b1; req_data[r] = w; req_last[r] = 1'(i == n - 1);
            ok = 0;
            for (int k = 0; k < 4000 && !ok; k++) begin
                @(negedge clk);
                if (req_ready[r]) ok = 1;
            end
            @(posedge clk); #1;
            req_valid[r] = 1'b0; req_last[r] = 1'b0;
            if (!ok) begin
                chk(1'b0, "handshake_timeout", 32'(r), 32'h0);
                return;
            end
            if (stall > 0 && i < n - 1) begin
                repeat (stall) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 6000 && !ok; k++) begin
            @(negedge clk);
            if (!busy && lcd_cs && q0.size() == 0 && q1.size() == 0) ok = 1;
        end
        if (!ok) chk(1'b0, "idle_timeout", 32'({busy, lcd_cs}), 32'h1);
    endtask

    int rdy_before, m, n0, n1, s0, s1, d0, d1;
    bit ok;

    initial begin
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0;
        rdy_cnt[0] = 0; rdy_cnt[1] = 0; mon_low_len = 0; mon_gap_len = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(lcd_cs == 1'b1,   "reset_cs",   32'(lcd_cs),   32'h1);
        chk(lcd_clk == 1'b0,  "reset_sck",  32'(lcd_clk),  32'h0);
        chk(lcd_rs == 1'b1,   "reset_rs",   32'(lcd_rs),   32'h1);
        chk(lcd_data == 1'b1, "reset_data", 32'(lcd_data), 32'h1);
        chk(grant == 2'b00 && !busy, "reset_grant_busy", 32'({grant, busy}), 32'h0);
        chk(req_ready == 2'b00, "reset_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // Single command byte: CS low for LOAD + one byte + hold
        drive_burst(0, 1, 0, 0, 9'h011, 9'h000, 1'b0);
        wait_idle();
        chk(mon_low_len == int'(BYTE_T + CLK_DIV + 1), "single_byte_cs_low", 32'(mon_low_len), 32'(BYTE_T + CLK_DIV + 1));

        // Two data bytes in one burst
        rdy_before = rdy_cnt[1];
        drive_burst(1, 2, 0, 0, 9'h1F8, 9'h100, 1'b0);
        wait_idle();
        chk(rdy_cnt[1] - rdy_before == 2, "two_byte_ready_pulses", 32'(rdy_cnt[1] - rdy_before), 32'h2);
        chk(mon_low_len == int'(2 * (BYTE_T + 1) + CLK_DIV), "two_byte_cs_low", 32'(mon_low_len), 32'(2 * (BYTE_T + 1) + CLK_DIV));

        // Simultaneous requests, twice; second burst follows after gap + idle cycle
        for (int rep = 0; rep < 2; rep++) begin
            fork
                drive_burst(0, 1, 0, 0, 9'h000, 9'h000, 1'b1);
                drive_burst(1, 1, 0, 0, 9'h000, 9'h000, 1'b1);
            join
            wait_idle();
            chk(mon_gap_len == int'(CS_GAP + 1), "back_to_back_gap", 32'(mon_gap_len), 32'(CS_GAP + 1));
        end

        // Valid withdrawn 10 cycles past the end of the first byte: LOAD stalls
        drive_burst(1, 2, BYTE_T + 10, 0, 9'h0A5, 9'h15A, 1'b0);
        wait_idle();
        chk(mon_low_len == int'(2 * (BYTE_T + 1) + CLK_DIV + 10), "stall_cs_low", 32'(mon_low_len), 32'(2 * (BYTE_T + 1) + CLK_DIV + 10));

        // req0 arrives mid-burst of req1 and must wait
        fork
            drive_burst(1, 3, 0, 0, 9'h000, 9'h000, 1'b1);
            drive_burst(0, 2, 0, 5, 9'h000, 9'h000, 1'b1);
        join
        wait_idle();

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            m  = $urandom_range(0, 2);
            n0 = $urandom_range(1, 3); n1 = $urandom_range(1, 3);
            s0 = $urandom_range(0, 45); s1 = $urandom_range(0, 45);
            d0 = $urandom_range(0, 3);  d1 = $urandom_range(0, 3);
            if (m == 0) drive_burst(0, n0, s0, d0, 9'h000, 9'h000, 1'b1);
            else if (m == 1) drive_burst(1, n1, s1, d1, 9'h000, 9'h000, 1'b1);
            else fork
                drive_burst(0, n0, s0, d0, 9'h000, 9'h000, 1'b1);
                drive_burst(1, n1, s1, d1, 9'h000, 9'h000, 1'b1);
            join
            wait_idle();
        end

        // Reset in the middle of a byte
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_data[0] = 9'h1C3; req_last[0] = 1'b1;
        ok = 0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            if (bits == 4) ok = 1;
        end
        chk(ok, "reach_bit4", 32'(bits), 32'h4);
        @(posedge clk); #1;
        reset = 1'b1; req_valid[0] = 1'b0; req_last[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk(lcd_cs == 1'b1 && lcd_clk == 1'b0, "midbyte_reset_pins", 32'({lcd_cs, lcd_clk}), 32'h2);
        chk(grant == 2'b00 && !busy, "midbyte_reset_grant", 32'({grant, busy}), 32'h0);
        chk(lcd_rs == 1'b1 && lcd_data == 1'b1, "midbyte_reset_rs_data", 32'({lcd_rs, lcd_data}), 32'h3);
        @(posedge clk); #1 reset = 1'b0;
        q0.delete(); q1.delete();
        drive_burst(0, 1, 0, 0, 9'h0C3, 9'h000, 1'b0);
        wait_idle();
        chk(mon_low_len == int'(BYTE_T + CLK_DIV + 1), "post_reset_cs_low", 32'(mon_low_len), 32'(BYTE_T + CLK_DIV + 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
